// File: rtl/pe_seq_controller.sv
// Main sequencer for the conv PE: start handshake, start-pointer search, N-stage pipeline fill/drain,
// filter/stride/IFMAP stepping, psum read-modify-write, abort and sticky error stall. Option: PE_PERF_CNT_EN.
module pe_seq_controller #(
   parameter int FILTER_ADDR_WIDTH = 8,
   parameter int PIPE_DEPTH        = 3,
   parameter int NUM_CH            = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         if_empty,
   input  logic                         reading_empty,
   input  logic [FILTER_ADDR_WIDTH-1:0] filter_waddr,
   input  logic [NUM_CH-1:0]            ch_cannot_read,
   input  logic                         sp_valid,
   input  logic                         f_co,
   input  logic                         go_next_stride,
   input  logic                         stride_ended,
   input  logic                         go_next_filter,
   input  logic                         is_last_filter,
   input  logic                         psum_mode,
   input  logic                         psum_valid,
   input  logic                         can_read_psum,
   input  logic                         psum_co,
   input  logic [1:0]                   wr_stall,
   input  logic                         error,
   output logic                         chip_en,
   output logic                         global_rst,
   output logic                         en_p_traverse,
   output logic [PIPE_DEPTH-1:0]        stage_en,
   output logic                         en_f_counter,
   output logic                         rst_f_counter,
   output logic                         next_stride,
   output logic                         next_filter,
   output logic                         rst_stride,
   output logic                         next_start,
   output logic                         rst_ctx,
   output logic                         psum_ren,
   output logic                         next_psum_raddr,
   output logic                         next_psum_waddr,
   output logic                         done,
   output logic                         stall_signal,
   output logic                         busy
`ifdef PE_PERF_CNT_EN
   ,
   output logic [31:0]                  freeze_cycles
`endif
);

   localparam int CW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [CW-1:0] FC_LAST = CW'(PIPE_DEPTH - 2);
   localparam logic [CW-1:0] DC_LAST = CW'(PIPE_DEPTH - 1);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ARM       = 4'd1,
      S_WAIT_DATA = 4'd2,
      S_FIND_SP   = 4'd3,
      S_FILL      = 4'd4,
      S_RUN       = 4'd5,
      S_NEXT_IF   = 4'd6,
      S_UPDATE_SP = 4'd7,
      S_NEXT_PSUM = 4'd8,
      S_READ_REQ  = 4'd9,
      S_WRITE_REQ = 4'd10,
      S_WAIT_WR   = 4'd11,
      S_ADD_NEXT  = 4'd12,
      S_DRAIN     = 4'd13,
      S_STALL     = 4'd14
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] fc_q, fc_d, dc_q, dc_d;
   logic          freeze_s, run_s;

   assign freeze_s = reading_empty | (|ch_cannot_read) | ~sp_valid | (is_last_filter & go_next_filter);
   assign run_s    = ~freeze_s & ~f_co;

   // State and fill/drain counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         fc_q    <= '0;
         dc_q    <= '0;
      end else begin
         state_q <= state_d;
         fc_q    <= fc_d;
         dc_q    <= dc_d;
      end
   end

   // Next-state and per-state outputs; abort/error overrides applied last
   always_comb begin
      state_d         = state_q;
      fc_d            = fc_q;
      dc_d            = dc_q;
      global_rst      = 1'b0;
      en_p_traverse   = 1'b0;
      stage_en        = '0;
      en_f_counter    = 1'b0;
      rst_f_counter   = 1'b0;
      next_stride     = 1'b0;
      next_filter     = 1'b0;
      rst_stride      = 1'b0;
      next_start      = 1'b0;
      rst_ctx         = 1'b0;
      psum_ren        = 1'b0;
      next_psum_raddr = 1'b0;
      next_psum_waddr = 1'b0;
      done            = 1'b0;
      stall_signal    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_ARM;
            else       state_d = S_IDLE;
         end
         S_ARM: begin
            global_rst = 1'b1;
            if (!start) state_d = S_WAIT_DATA;
            else        state_d = S_ARM;
         end
         S_WAIT_DATA: begin
            if (!if_empty && (filter_waddr != '0)) state_d = S_FIND_SP;
            else                                   state_d = S_WAIT_DATA;
         end
         S_FIND_SP: begin
            en_p_traverse = ~sp_valid;
            if (sp_valid) state_d = S_FILL;
            else          state_d = S_FIND_SP;
         end
         S_FILL: begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
               stage_en[k] = ~freeze_s && (CW'(k) <= fc_q);
            end
            if (freeze_s)              fc_d = fc_q;
            else if (fc_q == FC_LAST)  state_d = S_RUN;
            else                       fc_d = fc_q + {{(CW-1){1'b0}}, 1'b1};
         end
         S_RUN: begin
            stage_en     = {PIPE_DEPTH{run_s}};
            en_f_counter = run_s;
            next_stride  = run_s & go_next_stride & ~stride_ended;
            next_filter  = ~freeze_s & go_next_filter;
            rst_stride   = ~freeze_s & go_next_filter;
            if (psum_mode)                            state_d = S_READ_REQ;
            else if (is_last_filter && go_next_filter) state_d = S_NEXT_IF;
            else if (f_co && !freeze_s)               state_d = S_NEXT_PSUM;
            else                                      state_d = S_RUN;
         end
         S_NEXT_IF: begin
            rst_ctx    = 1'b1;
            rst_stride = 1'b1;
            state_d    = S_UPDATE_SP;
         end
         S_UPDATE_SP: begin
            next_start = 1'b1;
            state_d    = S_RUN;
         end
         S_NEXT_PSUM: begin
            rst_f_counter   = 1'b1;
            next_psum_waddr = 1'b1;
            if (psum_mode)    state_d = S_READ_REQ;
            else if (psum_co) state_d = S_DRAIN;
            else              state_d = S_RUN;
         end
         S_READ_REQ: begin
            psum_ren = can_read_psum;
            if (psum_valid) state_d = S_WRITE_REQ;
            else            state_d = S_READ_REQ;
         end
         S_WRITE_REQ: begin
            rst_f_counter = 1'b1;
            state_d       = S_WAIT_WR;
         end
         S_WAIT_WR: begin
            case (wr_stall)
               2'b10:   state_d = S_ADD_NEXT;
               2'b11:   state_d = S_DRAIN;
               default: state_d = S_WAIT_WR;
            endcase
         end
         S_ADD_NEXT: begin
            next_psum_raddr = 1'b1;
            state_d         = S_READ_REQ;
         end
         S_DRAIN: begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
               stage_en[k] = (CW'(k) > dc_q);
            end
            if (dc_q == DC_LAST) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               dc_d = dc_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_STALL: begin
            stall_signal = 1'b1;
            state_d      = S_STALL;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort silences every action output for the cycle it is seen
      if (abort && (state_q != S_IDLE) && (state_q != S_STALL)) begin
         state_d         = S_IDLE;
         global_rst      = 1'b0;
         en_p_traverse   = 1'b0;
         stage_en        = '0;
         en_f_counter    = 1'b0;
         rst_f_counter   = 1'b0;
         next_stride     = 1'b0;
         next_filter     = 1'b0;
         rst_stride      = 1'b0;
         next_start      = 1'b0;
         rst_ctx         = 1'b0;
         psum_ren        = 1'b0;
         next_psum_raddr = 1'b0;
         next_psum_waddr = 1'b0;
         done            = 1'b0;
      end else begin
         state_d = state_d;
      end
      if (error && (state_q != S_IDLE)) begin
         state_d = S_STALL;
         done    = 1'b0;
      end else begin
         state_d = state_d;
      end
      if (state_d != S_FILL)  fc_d = '0;
      else                    fc_d = fc_d;
      if (state_d != S_DRAIN) dc_d = '0;
      else                    dc_d = dc_d;
   end

   assign chip_en = (state_q != S_IDLE);
   assign busy    = (state_q != S_IDLE) && (state_q != S_STALL);

`ifdef PE_PERF_CNT_EN
   logic [31:0] fcnt_q, fcnt_d;

   // Saturating count of frozen RUN/FILL cycles, cleared when a run is armed
   always_comb begin
      fcnt_d = fcnt_q;
      if (state_q == S_ARM)
         fcnt_d = 32'd0;
      else if (((state_q == S_RUN) || (state_q == S_FILL)) && freeze_s && (fcnt_q != 32'hFFFF_FFFF))
         fcnt_d = fcnt_q + 32'd1;
      else
         fcnt_d = fcnt_q;
   end

   // Perf counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) fcnt_q <= 32'd0;
      else          fcnt_q <= fcnt_d;
   end

   assign freeze_cycles = fcnt_q;
`endif

endmodule
